// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state and RMW context for the fetch/data RAM arbiter.
// Pure type/constant package, no logic.
package mem_arb_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        ARB = 1'b0,
        RMW = 1'b1
    } arb_state_t;

    // Sub-word store held across the read half of a read-modify-write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } rmw_ctx_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, load/store port and RAM port bundled for the arbiter.
// master = core + RAM side, slave = arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_wren, mem_address, mem_data,
        output mem_q
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_wren, mem_address, mem_data,
        input  mem_q
    );

endinterface

// File: rtl/mem_arbiter_byte_merge.sv
// Combinational byte-lane merge of a new word into an old word, zero latency.
// No flow control; lane i takes new_word when be[i] is set.
module byte_merge
    import mem_arb_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter, fetch vs load/store; grants same cycle, read data one cycle later.
// Losers hold req until gnt; fetch forced after STARVE_LIMIT data wins. BYTE_WRITE_EN adds sub-word RMW.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;

    logic              fetch_wins;
    logic              if_gnt;
    logic              d_gnt;
    logic              if_rvalid;
    logic              d_rvalid;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

`ifdef BYTE_WRITE_EN
    rmw_ctx_t          ctx;
    logic              ctx_load;
    logic [DATA_W-1:0] merged;

    byte_merge u_merge (
        .old_word (bus.mem_q),
        .new_word (ctx.wdata),
        .be       (ctx.be),
        .merged   (merged)
    );
`else
    logic be_unused;
    assign be_unused = ^bus.d_be;
`endif

    assign fetch_wins = bus.if_req && (!bus.d_req || starve_cnt == LIMIT_C);

    // Everything is gated by rst so a reset landing on the RMW write cycle aborts it.
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        wren      = 1'b0;
        addr      = '0;
        wdata     = '0;
`ifdef BYTE_WRITE_EN
        ctx_load  = 1'b0;
`endif
        if (!rst) begin
            case (state)
                ARB: begin
                    if (fetch_wins) begin
                        if_gnt = 1'b1;
                        addr   = bus.if_addr;
                    end else if (bus.d_req) begin
                        d_gnt = 1'b1;
                        if (!bus.d_we) begin
                            addr = bus.d_addr;
                        end else begin
`ifdef BYTE_WRITE_EN
                            if (bus.d_be == {BE_W{1'b1}}) begin
                                wren  = 1'b1;
                                addr  = bus.d_addr;
                                wdata = bus.d_wdata;
                            end else if (bus.d_be != '0) begin
                                addr      = bus.d_addr;
                                ctx_load  = 1'b1;
                                state_nxt = RMW;
                            end
`else
                            wren  = 1'b1;
                            addr  = bus.d_addr;
                            wdata = bus.d_wdata;
`endif
                        end
                    end
                end
`ifdef BYTE_WRITE_EN
                RMW: begin
                    wren      = 1'b1;
                    addr      = ctx.addr;
                    wdata     = merged;
                    state_nxt = ARB;
                end
`endif
                default: state_nxt = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
`ifdef BYTE_WRITE_EN
            ctx        <= '0;
`endif
        end else begin
            state     <= state_nxt;
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt && !bus.d_we;
            if (!bus.if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && starve_cnt != LIMIT_C) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
`ifdef BYTE_WRITE_EN
            if (ctx_load) begin
                ctx <= '{addr: bus.d_addr, wdata: bus.d_wdata, be: bus.d_be};
            end
`endif
        end
    end

    assign bus.if_gnt      = if_gnt;
    assign bus.d_gnt       = d_gnt;
    assign bus.if_rvalid   = if_rvalid;
    assign bus.d_rvalid    = d_rvalid;
    assign bus.if_rdata    = if_rvalid ? bus.mem_q : '0;
    assign bus.d_rdata     = d_rvalid  ? bus.mem_q : '0;
    assign bus.mem_wren    = wren;
    assign bus.mem_address = addr;
    assign bus.mem_data    = wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x32 RAM and read-data scoreboards.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram    [256];
    logic [31:0] shadow [256];
    logic [31:0] exp_if [$];
    logic [31:0] exp_d  [$];
    logic [31:0] mon_e;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, 8'hC3, b ^ 8'h5A};
    endfunction

    // RAM: address registered, write at end of cycle, read returns old data.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (bus.mem_wren) begin
            ram[bus.mem_address[7:0]] <= bus.mem_data;
        end
        bus.mem_q <= ram[bus.mem_address[7:0]];
    end

    always @(negedge clk) begin
        if (!rst && !ram_init) begin
            total++;
            if (bus.if_rvalid) begin
                assert (exp_if.size() > 0) else begin
                    bad++; $error("FAIL if_rvalid_spurious observed=1 expected=0");
                end
                if (exp_if.size() > 0) begin
                    mon_e = exp_if.pop_front();
                    total++;
                    assert (bus.if_rdata === mon_e) else begin
                        bad++; $error("FAIL if_rdata observed=0x%08h expected=0x%08h", bus.if_rdata, mon_e);
                    end
                end
            end else begin
                assert (bus.if_rdata === 32'h0) else begin
                    bad++; $error("FAIL if_rdata_idle observed=0x%08h expected=0x00000000", bus.if_rdata);
                end
            end
            total++;
            if (bus.d_rvalid) begin
                assert (exp_d.size() > 0) else begin
                    bad++; $error("FAIL d_rvalid_spurious observed=1 expected=0");
                end
                if (exp_d.size() > 0) begin
                    mon_e = exp_d.pop_front();
                    total++;
                    assert (bus.d_rdata === mon_e) else begin
                        bad++; $error("FAIL d_rdata observed=0x%08h expected=0x%08h", bus.d_rdata, mon_e);
                    end
                end
            end else begin
                assert (bus.d_rdata === 32'h0) else begin
                    bad++; $error("FAIL d_rdata_idle observed=0x%08h expected=0x00000000", bus.d_rdata);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
    endtask

    task automatic drive_store(input int a, input logic [31:0] data, input logic [3:0] be);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = ADDR_W'(a);
        bus.d_wdata = data;
        bus.d_be    = be;
    endtask

    task automatic drive_load(input int a);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = ADDR_W'(a);
        bus.d_wdata = '0;
        bus.d_be    = '0;
    endtask

    initial begin
        int dn;
        logic fetch_pending;

        rst      = 1'b1;
        ram_init = 1'b1;
        idle();
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        bus.if_req = 1'b1;
        drive_store(3, 32'h12345678, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("rst_mem_wren", 32'(bus.mem_wren), 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'h0);

        step();
        rst      = 1'b0;
        ram_init = 1'b0;
        idle();

        // Fetch-only stream, one grant per cycle.
        for (int i = 0; i < 4; i++) begin
            step();
            bus.if_req  = 1'b1;
            bus.if_addr = ADDR_W'(i);
            exp_if.push_back(shadow[i]);
            @(negedge clk);
            chk("fetch_gnt", 32'(bus.if_gnt), 32'h1);
            chk("fetch_addr", 32'(bus.mem_address), 32'(i));
            chk("fetch_wren", 32'(bus.mem_wren), 32'h0);
        end
        step();
        idle();
        @(negedge clk);
        chk("idle_mem_address", 32'(bus.mem_address), 32'h0);

        // Simultaneous store and fetch: data first, fetch next cycle.
        step();
        drive_store(16, 32'hDEADBEEF, 4'hF);
        bus.if_req  = 1'b1;
        bus.if_addr = '0;
        shadow[16]  = 32'hDEADBEEF;
        @(negedge clk);
        chk("both_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("both_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("store_wren", 32'(bus.mem_wren), 32'h1);
        chk("store_addr", 32'(bus.mem_address), 32'h10);
        chk("store_data", bus.mem_data, 32'hDEADBEEF);
        step();
        bus.d_req = 1'b0;
        exp_if.push_back(shadow[0]);
        @(negedge clk);
        chk("loser_if_gnt", 32'(bus.if_gnt), 32'h1);
        chk("loser_d_gnt", 32'(bus.d_gnt), 32'h0);
        step();
        idle();
        drive_load(16);
        exp_d.push_back(shadow[16]);
        @(negedge clk);
        chk("load_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("load_wren", 32'(bus.mem_wren), 32'h0);
        step();
        idle();

        // Starvation guard: data held 8 cycles against a pending fetch.
        dn = 0;
        fetch_pending = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            drive_load(32 + dn);
            bus.if_req  = fetch_pending;
            bus.if_addr = ADDR_W'(7);
            if (c == STARVE_LIMIT) begin
                exp_if.push_back(shadow[7]);
                fetch_pending = 1'b0;
            end else begin
                exp_d.push_back(shadow[32 + dn]);
                dn++;
            end
            @(negedge clk);
            chk($sformatf("starve_if_gnt_c%0d", c), 32'(bus.if_gnt), 32'(c == STARVE_LIMIT));
            chk($sformatf("starve_d_gnt_c%0d", c), 32'(bus.d_gnt), 32'(c != STARVE_LIMIT));
        end
        step();
        idle();

`ifdef BYTE_WRITE_EN
        step();
        drive_store(5, 32'h11223344, 4'hF);
        shadow[5] = 32'h11223344;
        step();
        drive_store(5, 32'hAABBCCDD, 4'b0101);
        bus.if_req  = 1'b1;
        bus.if_addr = ADDR_W'(9);
        @(negedge clk);
        chk("rmw_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("rmw_read_wren", 32'(bus.mem_wren), 32'h0);
        chk("rmw_read_addr", 32'(bus.mem_address), 32'h5);
        step();
        bus.d_req = 1'b0;
        shadow[5] = 32'h11BB33DD;
        @(negedge clk);
        chk("rmw_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("rmw_d_gnt2", 32'(bus.d_gnt), 32'h0);
        chk("rmw_wren", 32'(bus.mem_wren), 32'h1);
        chk("rmw_addr", 32'(bus.mem_address), 32'h5);
        chk("rmw_data", bus.mem_data, 32'h11BB33DD);
        step();
        exp_if.push_back(shadow[9]);
        @(negedge clk);
        chk("post_rmw_if_gnt", 32'(bus.if_gnt), 32'h1);
        step();
        idle();

        // Zero byte-enable store is accepted but touches nothing.
        drive_store(5, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        chk("be0_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("be0_wren", 32'(bus.mem_wren), 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("be0_next_wren", 32'(bus.mem_wren), 32'h0);

        // Reset on the RMW write cycle aborts the merge.
        step();
        drive_store(5, 32'h99999999, 4'b0011);
        @(negedge clk);
        chk("rst_rmw_d_gnt", 32'(bus.d_gnt), 32'h1);
        step();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rmw_wren", 32'(bus.mem_wren), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_wren", 32'(bus.mem_wren), 32'h0);
        chk("after_rst_d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("after_rst_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("after_rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("after_rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("after_rst_mem_data", bus.mem_data, 32'h0);
        step();
        drive_load(5);
        exp_d.push_back(shadow[5]);
        @(negedge clk);
        chk("reload5_d_gnt", 32'(bus.d_gnt), 32'h1);
        step();
        idle();
`else
        step();
        drive_store(6, 32'hAABBCCDD, 4'b0001);
        shadow[6] = 32'hAABBCCDD;
        @(negedge clk);
        chk("nobe_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("nobe_wren", 32'(bus.mem_wren), 32'h1);
        chk("nobe_data", bus.mem_data, 32'hAABBCCDD);
        step();
        idle();
        bus.if_req  = 1'b1;
        bus.if_addr = ADDR_W'(9);
        exp_if.push_back(shadow[9]);
        @(negedge clk);
        chk("nobe_next_wren", 32'(bus.mem_wren), 32'h0);
        chk("nobe_next_if_gnt", 32'(bus.if_gnt), 32'h1);
        step();
        idle();
        drive_load(6);
        exp_d.push_back(shadow[6]);
        @(negedge clk);
        chk("reload6_d_gnt", 32'(bus.d_gnt), 32'h1);
        step();
        idle();
`endif

        repeat (3) step();
        @(negedge clk);
        chk("scoreboard_if_left", 32'(exp_if.size()), 32'h0);
        chk("scoreboard_d_left", 32'(exp_d.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port 256×32 word RAM between the CPU instruction-fetch port and the load/store data port. Grants at most one RAM access per cycle, returns read data with the RAM's fixed one-cycle latency and guards fetch against starvation. Optionally performs read-modify-write for sub-word stores, since the RAM has no byte enables. Sits between the core's fetch/memory stages and the RAM.

## Interface

- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before fetch is forced to win.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  30  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt).
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  30  data word address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables, bit i ↔ bits 8i+7:8i.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (cycle after load grant).
- d_rdata  out  32  load data.
- mem_wren  out  1  RAM write enable.
- mem_address  out  30  RAM word address.
- mem_data  out  32  RAM write data.
- mem_q  in  32  RAM read data (address registered inside RAM).

## Operation

- FSM states: ARB, RMW (RMW only with BYTE_WRITE_EN).
- ARB: one grant per cycle, combinational from current requests. Priority: data > fetch, unless starve_cnt == STARVE_LIMIT and if_req, then fetch wins.
- starve_cnt: +1 on each data grant while if_req high and not granted; cleared on fetch grant or if_req low; saturates at STARVE_LIMIT.
- Granted read: mem_address = req addr, mem_wren = 0; next cycle *_rvalid = 1, *_rdata = mem_q. Grants may issue back-to-back every cycle.
- Granted full store: mem_address = d_addr, mem_data = d_wdata, mem_wren = 1 same cycle; no d_rvalid.
- No grant: mem_address = 0, mem_wren = 0, mem_data = 0.
- *_rdata forced to 0 when corresponding rvalid is 0.
- Simultaneous if_req and d_req: exactly one gnt; loser keeps request, served a later cycle.

## Timing

- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren = 0; rdata = 0; state = ARB; starve_cnt = 0.
- Read latency: grant cycle N → rvalid cycle N+1. Store: written at end of cycle N.
- rst mid-RMW: merge write aborted, no RAM write, state → ARB.
- Request inputs sampled only in grant cycle; changes after gnt ignored.

## Configuration

- BYTE_WRITE_EN defined: store with d_be == 4'hF → full store as above. d_be ∈ {1..E}: cycle N d_gnt = 1, RAM read at d_addr, latch wdata/be/addr; state RMW in N+1: mem_wren = 1, mem_data = bytewise mux (be ? wdata : mem_q), no grants in N+1, return to ARB. d_be == 0: d_gnt, no RAM access.
- BYTE_WRITE_EN undefined: d_be ignored, every store is a full-word write, RMW state absent.

## Structure

- Package mem_arb_pkg: ADDR_W = 30, DATA_W = 32, BE_W = 4, state enum (ARB, RMW).
- Sub-module byte_merge: combinational 4-lane mux (old word, new word, be) → merged word; instantiated only under BYTE_WRITE_EN.

## Test plan

- Fetch only, if_addr 0..3 over four cycles → if_gnt each cycle, if_rvalid next cycle with if_rdata = RAM[0..3].
- d_req store 0xDEADBEEF @0x10 and if_req @0x0 same cycle → d_gnt first, if_gnt next cycle; later load @0x10 returns 0xDEADBEEF.
- d_req held high for 8 cycles, if_req high, STARVE_LIMIT = 4 → data grants cycles 0–3, fetch grant cycle 4, data resumes cycle 5.
- (BYTE_WRITE_EN) RAM[5] = 0x11223344, store 0xAABBCCDD be = 4'b0101 → RAM[5] = 0x11BB33DD; if_req pending receives no grant in RMW cycle.
- rst asserted in RMW cycle of byte store → RAM word unchanged, all outputs 0 next cycle.
- Without BYTE_WRITE_EN, be = 4'b0001 store 0xAABBCCDD → RAM word = 0xAABBCCDD.
